ac97_frame_controller: RTL
==========================

AC97_FRAME_CONTROLLER -- requirements
Module: ac97_frame_controller

Interface
REQ-001 SHALL have parameter SYNC_LEN, default 16: number of bit clocks sync is high per frame.
REQ-002 SHALL have parameter RX_OFFSET, default 2: bit clocks from frame-counter value k to sdata_in carrying frame bit k.
REQ-003 raw_bit_clk  in  1  AC97 bit clock (12.288 MHz); all logic on its rising edge.
REQ-004 reset_b  in  1  reset, asynchronous, active-low.
REQ-005 sync  out  1  AC97 frame sync to codec.
REQ-006 sdata_out  out  1  serial frame to codec.
REQ-007 sdata_in  in  1  serial frame from codec.
REQ-008 pcm_valid/pcm_ready  in/out  1/1  DAC sample handshake; pcm_left, pcm_right  in  20/20  signed samples.
REQ-009 cmd_valid/cmd_ready  in/out  1/1  register command handshake; cmd_rd  in  1 (1 = read); cmd_addr  in  7; cmd_data  in  16.
REQ-010 rd_valid  out  1  one-cycle pulse; rd_addr  out  7; rd_data  out  16  codec register read response.
REQ-011 adc_valid  out  1  one-cycle pulse; adc_left, adc_right  out  20/20  captured ADC samples.
REQ-012 codec_ready  out  1  codec reported ready (slot 0 tag bit 15 received high).

Function
REQ-013 SHALL keep frame counter fc, 8 bits, 0..255, incrementing every cycle, wrapping 255->0.
REQ-014 sync SHALL be 1 for fc 0..SYNC_LEN-1, else 0.
REQ-015 Frame is 256 bits, MSB first: slot 0 bits 0-15, slot 1 bits 16-35, slot 2 bits 36-55, slot 3 bits 56-75, slot 4 bits 76-95, bits 96-255 zero.
REQ-016 sdata_out at fc=k SHALL carry frame bit k-1 (k=1..255); at fc=0 it carries 0.
REQ-017 Frame contents SHALL be latched into a 256-bit shift register at fc=0 and not change mid-frame.
REQ-018 Slot 0: bit15 = frame valid = codec_ready; bit14 = bit13 = command present (bit13 only for writes); bit12 = bit11 = PCM present; rest 0.
REQ-019 Slot 1 = {cmd_rd, cmd_addr, 12'h000}; slot 2 = {cmd_data, 4'h0} for writes, zero for reads; slots zero when no command.
REQ-020 Slots 3/4 = pcm_left/pcm_right popped from FIFO at fc=0 only if FIFO non-empty and codec_ready; else zero, tags 12/11 clear.
REQ-021 PCM FIFO depth 2; pcm_ready = not full; push and pop in same cycle SHALL both succeed when FIFO holds 1 entry.
REQ-022 Command holding register: cmd_ready = 1 when empty and codec_ready; accepted command consumed at next fc=0; pending command SHALL not be sent twice.
REQ-023 Receiver SHALL shift sdata_in each cycle; rx frame bit j is sampled at fc = (j+RX_OFFSET) mod 256.
REQ-024 When rx slot 0 complete: codec_ready <= rx bit 15 (sticky 1 once set until reset).
REQ-025 After rx slot 2 complete, if rx tags 14 and 13 set: rd_valid pulse, rd_addr = slot1[18:12], rd_data = slot2[19:4].
REQ-026 After rx slot 4 complete, if rx tag 12 set: adc_valid pulse with adc_left = slot3, adc_right = slot4 (tag 11 clear -> adc_right = 0).
REQ-027 State machine: WAIT_READY (frames sent with all tags 0, no handshakes accepted) -> RUN on codec_ready rising; RUN -> WAIT_READY only on reset.

Reset
REQ-028 On reset_b low, asynchronously: fc=0, sync=0, sdata_out=0, FIFO empty, command dropped, pcm_ready=0, cmd_ready=0, rd_valid=0, adc_valid=0, data outputs 0, codec_ready=0, state WAIT_READY.
REQ-029 Reset mid-frame SHALL abandon the frame; first frame after release starts at fc=0 on first rising edge.

Structure
REQ-030 Package ac97_pkg SHALL hold FRAME_BITS=256, slot start/length constants, tag bit indices, state enum.
REQ-031 Sub-module ac97_pcm_fifo (2-entry, 40-bit) SHALL implement the PCM buffer.

Verification
REQ-032 Reset release, codec tag15 low -> frames with slot0=0x0000, pcm_ready=0; tag15 high -> codec_ready=1 within one frame.
REQ-033 Write cmd addr 0x02 data 0x8000 -> sent slot0=0xE000, slot1=0x02000, slot2=0x80000, cmd_ready low until fc=0.
REQ-034 Push pcm_left=0x12345, pcm_right=0xFEDCB -> next frame slot0=0x9800, slots 3/4 carry values; empty FIFO -> slot0=0x8000.
REQ-035 Codec model returns slot0=0x9000 and slot3=0xABABA -> adc_valid one cycle, adc_left=0xABABA, adc_right=0.
REQ-036 Read cmd addr 0x7C, codec replies slot1=0x7C000, slot2=0x4E530 -> rd_valid, rd_addr=0x7C, rd_data=0x4E53.
REQ-037 Assert reset_b low at fc=100 -> sync, sdata_out, codec_ready 0 immediately; restart at fc=0; sync high exactly 16 cycles of 256.

Source files
------------

// File: rtl/ac97_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ac97_pkg
// Description : Shared AC97 frame geometry, slot-0 tag positions and the
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ac97_pkg;

    // Frame geometry, in frame bit positions (bit 0 is sent first)
    localparam int FRAME_BITS  = 256;
    localparam int SLOT0_START = 0;
    localparam int SLOT0_LEN   = 16;
    localparam int SLOT_LEN    = 20;
    localparam int SLOT1_START = 16;
    localparam int SLOT2_START = 36;
    localparam int SLOT3_START = 56;
    localparam int SLOT4_START = 76;

    // Bit indices inside the 16-bit slot-0 tag word
    localparam int TAG_VALID    = 15;
    localparam int TAG_CMD_ADDR = 14;
    localparam int TAG_CMD_DATA = 13;
    localparam int TAG_PCM_L    = 12;
    localparam int TAG_PCM_R    = 11;

    typedef enum logic [0:0] {
        ST_WAIT_READY = 1'b0,
        ST_RUN        = 1'b1
    } ac97_state_t;

endpackage
`default_nettype wire

// File: rtl/ac97_pcm_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ac97_pcm_fifo
// Description : Two-entry FIFO holding packed {left, right} PCM samples.
//               A push and a pop in the same cycle both take effect.
// Revision    : 1.0 - initial release
// ============================================================================
module ac97_pcm_fifo
    import ac97_pkg::*;
#(
    parameter int WIDTH = 2 * SLOT_LEN
) (
    input  logic             raw_bit_clk,
    input  logic             reset_b,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push     = i_push && (r_count != 2'd2);
    assign w_pop      = i_pop  && (r_count != 2'd0);
    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == 2'd0);
    assign o_full     = (r_count == 2'd2);

    // Storage, pointers and occupancy update
    always_ff @(posedge raw_bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ac97_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : ac97_frame_controller
// Description : AC97 link controller. Generates sync, serialises a 256-bit
//               frame (tags, command, PCM) and decodes the codec's frame into
//               register read responses and ADC samples.
// Revision    : 1.0 - initial release
// ============================================================================
module ac97_frame_controller
    import ac97_pkg::*;
#(
    parameter int SYNC_LEN  = 16,
    parameter int RX_OFFSET = 2
) (
    input  logic        raw_bit_clk,
    input  logic        reset_b,
    output logic        o_sync,
    output logic        o_sdata_out,
    input  logic        i_sdata_in,
    input  logic        i_pcm_valid,
    output logic        o_pcm_ready,
    input  logic [19:0] i_pcm_left,
    input  logic [19:0] i_pcm_right,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_rd,
    input  logic [6:0]  i_cmd_addr,
    input  logic [15:0] i_cmd_data,
    output logic        o_rd_valid,
    output logic [6:0]  o_rd_addr,
    output logic [15:0] o_rd_data,
    output logic        o_adc_valid,
    output logic [19:0] o_adc_left,
    output logic [19:0] o_adc_right,
    output logic        o_codec_ready
);

    // Counter values at which the last bit of an rx slot is being sampled
    localparam logic [8:0] c_SYNC_LEN    = 9'(SYNC_LEN);
    localparam logic [7:0] c_RX_S0_DONE  = 8'((SLOT0_START + SLOT0_LEN - 1 + RX_OFFSET) % FRAME_BITS);
    localparam logic [7:0] c_RX_S2_DONE  = 8'((SLOT2_START + SLOT_LEN - 1 + RX_OFFSET) % FRAME_BITS);
    localparam logic [7:0] c_RX_S4_DONE  = 8'((SLOT4_START + SLOT_LEN - 1 + RX_OFFSET) % FRAME_BITS);

    logic [7:0]            r_fc;
    logic                  r_sync;
    logic                  r_sdo;
    logic [FRAME_BITS-1:0] r_tx_shift;
    ac97_state_t           r_state;
    logic                  r_codec_ready;
    logic                  r_cmd_full;
    logic                  r_cmd_rd;
    logic [6:0]            r_cmd_addr;
    logic [15:0]           r_cmd_data;
    logic [38:0]           r_rx_shift;
    logic                  r_rx_cmd;
    logic                  r_rx_pcm_l;
    logic                  r_rx_pcm_r;
    logic                  r_rd_valid;
    logic [6:0]            r_rd_addr;
    logic [15:0]           r_rd_data;
    logic                  r_adc_valid;
    logic [19:0]           r_adc_left;
    logic [19:0]           r_adc_right;

    logic                  w_run;
    logic                  w_frame_start;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [39:0]           w_fifo_data;
    logic                  w_cmd_accept;
    logic                  w_cmd_send;
    logic [15:0]           w_slot0;
    logic [19:0]           w_slot1;
    logic [19:0]           w_slot2;
    logic [19:0]           w_slot3;
    logic [19:0]           w_slot4;
    logic [FRAME_BITS-1:0] w_frame;
    logic [39:0]           w_rx_next;

    assign w_run         = (r_state == ST_RUN);
    assign w_frame_start = (r_fc == 8'd0);
    assign o_pcm_ready   = w_run && !w_fifo_full;
    assign o_cmd_ready   = w_run && r_codec_ready && !r_cmd_full;
    assign w_fifo_push   = i_pcm_valid && o_pcm_ready;
    assign w_fifo_pop    = w_frame_start && w_run && r_codec_ready && !w_fifo_empty;
    assign w_cmd_accept  = i_cmd_valid && o_cmd_ready;
    assign w_cmd_send    = w_frame_start && w_run && r_cmd_full;
    assign w_rx_next     = {r_rx_shift, i_sdata_in};

    ac97_pcm_fifo #(
        .WIDTH (40)
    ) u_pcm_fifo (
        .raw_bit_clk (raw_bit_clk),
        .reset_b     (reset_b),
        .i_push      (w_fifo_push),
        .i_push_data ({i_pcm_left, i_pcm_right}),
        .i_pop       (w_fifo_pop),
        .o_pop_data  (w_fifo_data),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    // Assemble the next outgoing frame; only sampled when the counter is 0
    always_comb begin
        w_slot0               = '0;
        w_slot0[TAG_VALID]    = w_run && r_codec_ready;
        w_slot0[TAG_CMD_ADDR] = w_cmd_send;
        w_slot0[TAG_CMD_DATA] = w_cmd_send && !r_cmd_rd;
        w_slot0[TAG_PCM_L]    = w_fifo_pop;
        w_slot0[TAG_PCM_R]    = w_fifo_pop;
        w_slot1 = w_cmd_send ? {r_cmd_rd, r_cmd_addr, 12'h000} : '0;
        w_slot2 = (w_cmd_send && !r_cmd_rd) ? {r_cmd_data, 4'h0} : '0;
        w_slot3 = w_fifo_pop ? w_fifo_data[39:20] : '0;
        w_slot4 = w_fifo_pop ? w_fifo_data[19:0]  : '0;
        w_frame = '0;
        w_frame[FRAME_BITS-1-SLOT0_START -: SLOT0_LEN] = w_slot0;
        w_frame[FRAME_BITS-1-SLOT1_START -: SLOT_LEN]  = w_slot1;
        w_frame[FRAME_BITS-1-SLOT2_START -: SLOT_LEN]  = w_slot2;
        w_frame[FRAME_BITS-1-SLOT3_START -: SLOT_LEN]  = w_slot3;
        w_frame[FRAME_BITS-1-SLOT4_START -: SLOT_LEN]  = w_slot4;
    end

    // Frame counter, sync and transmit shifter (frame bit k-1 leaves at count k)
    always_ff @(posedge raw_bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_fc       <= 8'd0;
            r_sync     <= 1'b0;
            r_sdo      <= 1'b0;
            r_tx_shift <= '0;
        end else begin
            r_fc   <= r_fc + 8'd1;
            r_sync <= ({1'b0, r_fc} < c_SYNC_LEN);
            if (w_frame_start) begin
                r_tx_shift <= w_frame;
                r_sdo      <= 1'b0;
            end else begin
                r_sdo      <= r_tx_shift[FRAME_BITS-1];
                r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    // Link state: wait for the codec to report ready, then run until reset
    always_ff @(posedge raw_bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state       <= ST_WAIT_READY;
            r_codec_ready <= 1'b0;
        end else begin
            if (r_fc == c_RX_S0_DONE && w_rx_next[TAG_VALID]) begin
                r_codec_ready <= 1'b1;
            end
            case (r_state)
                ST_WAIT_READY: if (r_codec_ready) r_state <= ST_RUN;
                ST_RUN:        r_state <= ST_RUN;
                default:       r_state <= ST_WAIT_READY;
            endcase
        end
    end

    // Command holding register; emptied when its frame is latched
    always_ff @(posedge raw_bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cmd_full <= 1'b0;
            r_cmd_rd   <= 1'b0;
            r_cmd_addr <= '0;
            r_cmd_data <= '0;
        end else if (w_cmd_accept) begin
            r_cmd_full <= 1'b1;
            r_cmd_rd   <= i_cmd_rd;
            r_cmd_addr <= i_cmd_addr;
            r_cmd_data <= i_cmd_data;
        end else if (w_cmd_send) begin
            r_cmd_full <= 1'b0;
        end
    end

    // Receiver: the last 40 bits always hold the two most recent rx slots
    always_ff @(posedge raw_bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_rx_shift  <= '0;
            r_rx_cmd    <= 1'b0;
            r_rx_pcm_l  <= 1'b0;
            r_rx_pcm_r  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
            r_adc_valid <= 1'b0;
            r_adc_left  <= '0;
            r_adc_right <= '0;
        end else begin
            r_rx_shift  <= w_rx_next[38:0];
            r_rd_valid  <= 1'b0;
            r_adc_valid <= 1'b0;
            if (r_fc == c_RX_S0_DONE) begin
                r_rx_cmd   <= w_rx_next[TAG_CMD_ADDR] && w_rx_next[TAG_CMD_DATA];
                r_rx_pcm_l <= w_rx_next[TAG_PCM_L];
                r_rx_pcm_r <= w_rx_next[TAG_PCM_R];
            end
            // slot1 sits in [39:20], slot2 in [19:0]
            if (r_fc == c_RX_S2_DONE && r_rx_cmd) begin
                r_rd_valid <= 1'b1;
                r_rd_addr  <= w_rx_next[38:32];
                r_rd_data  <= w_rx_next[19:4];
            end
            // slot3 sits in [39:20], slot4 in [19:0]
            if (r_fc == c_RX_S4_DONE && r_rx_pcm_l) begin
                r_adc_valid <= 1'b1;
                r_adc_left  <= w_rx_next[39:20];
                r_adc_right <= r_rx_pcm_r ? w_rx_next[19:0] : 20'h0;
            end
        end
    end

    assign o_sync        = r_sync;
    assign o_sdata_out   = r_sdo;
    assign o_codec_ready = r_codec_ready;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_addr     = r_rd_addr;
    assign o_rd_data     = r_rd_data;
    assign o_adc_valid   = r_adc_valid;
    assign o_adc_left    = r_adc_left;
    assign o_adc_right   = r_adc_right;

endmodule
`default_nettype wire
